// File: rtl/riscv_pkg.sv
// Shared core constants: datapath width, NOP encoding, reset vector, fetch-queue depth.
package riscv_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction
endpackage

// File: rtl/instr_mem.sv
// Synchronous-read instruction ROM; contents are back-door loaded through mem.
module instr_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (en) rdata <= mem[addr];
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, one-deep read pipeline into a 2-entry {pc,instr} queue.
// FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fault and halt fetch.
module if_fetch_unit #(
  parameter int               XLEN       = riscv_pkg::XLEN,
  parameter int               IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0]  RESET_PC   = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            fetch_fault
);
  import riscv_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fq_ent_t;

  fq_ent_t [FQ_DEPTH-1:0] fq;
  logic [XLEN-1:0]        pc_q, inflight_pc, redir_pc;
  logic                   inflight, fault, pop, issue;
  logic [1:0]             count;
  logic [2:0]             occ;
  logic [QW-1:0]          wr_idx;
  logic [31:0]            rdata;

  instr_mem #(.DEPTH(IMEM_DEPTH)) imem (
    .clk   (clk),
    .en    (issue),
    .addr  (pc_q[AW+1:2]),
    .rdata (rdata)
  );

  assign out_valid = (count != 2'd0);
  assign out_pc    = fq[0].pc;
  assign out_instr = fq[0].instr;
  assign pop       = out_valid && out_ready;

  // Occupancy after this cycle's pop, counting the word still in flight.
  assign occ    = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue  = !redirect_valid && !fault && (occ < 3'd2);
  assign wr_idx = QW'(count - {1'b0, pop});

`ifdef FETCH_MISALIGN_CHECK_EN
  logic redir_bad;
  assign redir_pc  = redirect_pc;
  assign redir_bad = misaligned(redirect_pc[1:0]);

  always_ff @(posedge clk) begin
    if (!rst)                            fault <= 1'b0;
    else if (redirect_valid && redir_bad) fault <= 1'b1;
  end
`else
  logic [1:0] unused_lo;
  assign unused_lo = redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign fault     = 1'b0;
`endif

  assign fetch_fault = fault;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) fq[i] <= '{pc: '0, instr: NOP};
    end else if (redirect_valid) begin
      // Flush wins over push/issue; any returning read is dropped.
      count    <= 2'd0;
      inflight <= 1'b0;
      pc_q     <= redir_pc;
    end else begin
      if (pop)      fq[0]      <= fq[1];
      if (inflight) fq[wr_idx] <= '{pc: inflight_pc, instr: rdata};
      count    <= count - {1'b0, pop} + {1'b0, inflight};
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + XLEN'(4);
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b0, redirect_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, fetch_fault;
  logic [31:0] out_pc, out_instr;

  if_fetch_unit #(.XLEN(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] tmem [DEPTH];
  bit          infl = 0, mfault = 0, mrst = 1, mpop, miss;
  logic [31:0] mpc = '0, ipc = '0;
  int          msz;
  int          vectors = 0, miscompares = 0, pops4 = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return tmem[int'((a >> 2) % DEPTH)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: whole words move from "issued" to a delivery queue a cycle later.
  always @(posedge clk) begin
    if (rst && out_valid && out_ready && out_pc == 32'h4) pops4++;
    mrst = 0;
    if (!rst) begin
      q.delete(); infl = 0; mpc = 32'h0; mfault = 0; mrst = 1;
    end else if (redirect_valid) begin
      q.delete(); infl = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) mfault = 1;
      mpc = redirect_pc;
`else
      mpc = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      msz  = q.size();
      mpop = (msz != 0) && out_ready;
      if (mpop) void'(q.pop_front());
      if (infl) q.push_back('{pc: ipc, ins: word_at(ipc)});
      miss = !mfault && (msz + int'(infl) - int'(mpop)) < 2;
      infl = miss;
      if (miss) begin ipc = mpc; mpc = mpc + 32'd4; end
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("pc", out_pc, q[0].pc);
      chk("instr", out_instr, q[0].ins);
    end
    chk("fault", {31'b0, fetch_fault}, {31'b0, mfault});
    if (mrst) begin
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, NOPW);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_pc = t; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    bit found;
    logic [31:0] r;
    for (int i = 0; i < DEPTH; i++) tmem[i] = $urandom;
    tmem[0] = 32'h0050_0093; tmem[1] = 32'h00A0_0113;
    tmem[2] = 32'h0020_81B3; tmem[3] = 32'h4020_8233;
    tmem[16] = 32'h02A0_0513;
    for (int i = 0; i < DEPTH; i++) dut.imem.mem[i] = tmem[i];

    // Reset held, then release: first word two edges later
    repeat (5) tick();
    chk("lit_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("lit_rst_nop", out_instr, 32'h0000_0013);
    rst = 1'b1;
    tick();
    chk("lit_e0_valid", {31'b0, out_valid}, 32'h0);
    tick();
    chk("lit_e1_pc", out_pc, 32'h0);
    chk("lit_e1_instr", out_instr, 32'h0050_0093);
    tick(); chk("lit_s1_pc", out_pc, 32'h4); chk("lit_s1_instr", out_instr, 32'h00A0_0113);
    tick(); chk("lit_s2_pc", out_pc, 32'h8); chk("lit_s2_instr", out_instr, 32'h0020_81B3);
    tick(); chk("lit_s3_pc", out_pc, 32'hC); chk("lit_s3_instr", out_instr, 32'h4020_8233);

    // Stall with head at 0x8
    redir(32'h8);
    chk("lit_rd_gap0", {31'b0, out_valid}, 32'h0);
    tick(); chk("lit_rd_gap1", {31'b0, out_valid}, 32'h0);
    tick(); chk("lit_rd_pc", out_pc, 32'h8);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("lit_stall_pc", out_pc, 32'h8);
      chk("lit_stall_instr", out_instr, 32'h0020_81B3);
    end
    out_ready = 1'b1;
    tick(); chk("lit_resume_pc0", out_pc, 32'hC);
    tick(); chk("lit_resume_pc1", out_pc, 32'h10); chk("lit_resume_ins1", out_instr, tmem[4]);

    // Redirect while queue is full
    out_ready = 1'b0;
    repeat (3) tick();
    redir(32'h40);
    chk("lit_full_gap0", {31'b0, out_valid}, 32'h0);
    tick(); chk("lit_full_gap1", {31'b0, out_valid}, 32'h0);
    tick(); chk("lit_full_pc", out_pc, 32'h40); chk("lit_full_instr", out_instr, 32'h02A0_0513);
    out_ready = 1'b1;

    // Redirect coinciding with a pop of 0x4
    redir(32'h4);
    tick(); tick();
    chk("lit_head4", out_pc, 32'h4);
    pops4 = 0;
    redir(32'h8);
    chk("lit_rp_gap", {31'b0, out_valid}, 32'h0);
    tick(); tick();
    chk("lit_rp_pc", out_pc, 32'h8);
    chk("lit_rp_once", pops4, 32'd1);

    // Reset mid-stream at 0x20
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (out_valid && out_pc == 32'h20) found = 1;
      else tick();
    end
    chk("lit_reach_20", {31'b0, found}, 32'h1);
    rst = 1'b0;
    tick();
    chk("lit_mrst_valid", {31'b0, out_valid}, 32'h0);
    chk("lit_mrst_instr", out_instr, NOPW);
    rst = 1'b1;
    tick(); tick();
    chk("lit_mrst_pc", out_pc, 32'h0);
    chk("lit_mrst_ins", out_instr, 32'h0050_0093);

    // Misaligned redirect
    redir(32'h42);
    tick(); tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("lit_mis_fault", {31'b0, fetch_fault}, 32'h1);
    chk("lit_mis_valid", {31'b0, out_valid}, 32'h0);
    repeat (3) tick();
    chk("lit_mis_hold", {31'b0, out_valid}, 32'h0);
    rst = 1'b0; tick(); rst = 1'b1;
`else
    chk("lit_mis_pc", out_pc, 32'h40);
    chk("lit_mis_fault0", {31'b0, fetch_fault}, 32'h0);
`endif

    // Randomized traffic
    repeat (3000) begin
      out_ready      = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      case ($urandom_range(2))
        0:       r = $urandom;
        1:       r = $urandom_range(255);
        default: r = 32'hFFFF_FFF0 + $urandom_range(15);
      endcase
      if ($urandom_range(7) != 0) r[1:0] = 2'b00;
      redirect_pc = r;
      rst = ($urandom_range(99) != 0);
      tick();
    end
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
